// File: rtl/ctrl_encode_def.sv
// Shared encodings for the data-memory path: access type codes, access size
// decode and the load/store controller state encoding.
package ctrl_encode_def;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  // Returns the access size in bytes; 0 marks an invalid type code.
  function automatic logic [2:0] dm_size(input logic [2:0] acc_type);
    case (acc_type)
      dm_word:                           dm_size = 3'd4;
      dm_halfword, dm_halfword_unsigned: dm_size = 3'd2;
      dm_byte, dm_byte_unsigned:         dm_size = 3'd1;
      default:                           dm_size = 3'd0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    st_idle,
    st_acc0,
    st_acc1,
    st_resp
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: positions store data and byte enables across
// two memory words and extracts/extends load data from the fetched pair.
module lsu_align
  import ctrl_encode_def::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  acc_type,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [7:0]  be,
  output logic [31:0] rdata
);

  logic [7:0]  mask;
  logic [31:0] rword;

  always_comb begin
    {wdata_hi, wdata_lo} = {32'b0, wdata} << {off, 3'b000};

    case (dm_size(acc_type))
      3'd1:    mask = 8'h01;
      3'd2:    mask = 8'h03;
      3'd4:    mask = 8'h0f;
      default: mask = 8'h00;
    endcase
    be = mask << off;

    rword = 32'({hi, lo} >> {off, 3'b000});
    case (acc_type)
      dm_word:              rdata = rword;
      dm_halfword:          rdata = {{16{rword[15]}}, rword[15:0]};
      dm_halfword_unsigned: rdata = {16'b0, rword[15:0]};
      dm_byte:              rdata = {{24{rword[7]}}, rword[7:0]};
      dm_byte_unsigned:     rdata = {24'b0, rword[7:0]};
      default:              rdata = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: splits byte/halfword/word requests into one or two
// word-wide memory transactions and stalls the pipeline until completion.
module lsu_ctrl
  import ctrl_encode_def::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  lsu_state_e state, next;

  logic          we_q;
  logic [2:0]    type_q;
  logic [1:0]    off_q;
  logic [AW-3:0] waddr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic          split_q;
  logic [31:0]   lo_q;
  logic [31:0]   hi_q;

  logic [2:0]    req_size;
  logic [3:0]    span;
  logic          req_split;

  logic [31:0]   wdata_lo;
  logic [31:0]   wdata_hi;
  logic [7:0]    be_all;
  logic [31:0]   load_data;

  assign req_size  = dm_size(req_type);
  assign span      = {2'b00, req_addr[1:0]} + {1'b0, req_size};
  assign req_split = span > 4'd4;

  lsu_align u_align (
    .off      (off_q),
    .acc_type (type_q),
    .wdata    (wdata_q),
    .lo       (lo_q),
    .hi       (hi_q),
    .wdata_lo (wdata_lo),
    .wdata_hi (wdata_hi),
    .be       (be_all),
    .rdata    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      type_q  <= 3'b0;
      off_q   <= 2'b0;
      waddr_q <= '0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
    end else begin
      case (state)
        st_idle: if (req_valid) begin
          we_q    <= req_we;
          type_q  <= req_type;
          off_q   <= req_addr[1:0];
          waddr_q <= req_addr[AW-1:2];
          wdata_q <= req_wdata;
          err_q   <= (req_size == 3'd0);
          split_q <= req_split;
          lo_q    <= 32'b0;
          hi_q    <= 32'b0;
        end
        st_acc0: if (mem_ack) lo_q <= mem_rdata;
        st_acc1: if (mem_ack) hi_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Memory and response outputs decode purely from state and captured
  // registers, so nothing on req_* reaches mem_* in the same cycle.
  always_comb begin
    next      = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    mem_be    = 4'b0;
    case (state)
      st_idle: begin
        req_ready = 1'b1;
        if (req_valid) next = (req_size == 3'd0) ? st_resp : st_acc0;
      end
      st_acc0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = waddr_q;
        mem_wdata = we_q ? wdata_lo : 32'b0;
        mem_be    = we_q ? be_all[3:0] : 4'b1111;
        if (mem_ack) next = split_q ? st_acc1 : st_resp;
      end
      st_acc1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = waddr_q + {{(AW-3){1'b0}}, 1'b1};
        mem_wdata = we_q ? wdata_hi : 32'b0;
        mem_be    = we_q ? be_all[7:4] : 4'b1111;
        if (mem_ack) next = st_resp;
      end
      st_resp: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'b0 : load_data;
        next      = st_idle;
      end
      default: next = st_idle;
    endcase
  end

  assign stall = !req_ready;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl against a small 4-word memory
// model with configurable wait states and a transaction log.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tx_t;

  logic [31:0] memWords [0:3];
  int          waitStates = 0;
  int          waitCnt = 0;
  logic        ackEn = 1'b1;
  logic        forceAck = 1'b0;
  tx_t         txLog [$];
  int          rspCount = 0;
  int          testCount = 0;
  int          failCount = 0;

  lsu_ctrl #(.AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ack   = forceAck | (mem_req && ackEn && (waitCnt >= waitStates));
  assign mem_rdata = memWords[mem_addr[1:0]];

  // Memory model: preloads while reset is held, otherwise applies byte-enabled
  // writes and logs every acknowledged transaction.
  always @(posedge clk) begin
    if (rst) begin
      memWords[0] <= 32'h44332211;
      memWords[1] <= 32'h88776655;
      memWords[2] <= 32'h0;
      memWords[3] <= 32'h0;
      waitCnt     <= 0;
    end else begin
      if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
      else                     waitCnt <= 0;
      if (mem_req && mem_ack) begin
        txLog.push_back('{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata});
        if (mem_we)
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) memWords[mem_addr[1:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always @(negedge clk) if (rsp_valid) rspCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request, waits for acceptance and then for the response,
  // reporting latency in cycles from the accepting edge (bounded).
  task automatic applyStimulus(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat,
                               output logic [31:0] rdata, output logic err);
    @(negedge clk);
    checkOutput("ready_before_req", {31'b0, req_ready}, 32'd1);
    txLog.delete();
    req_valid = 1'b1;
    req_we    = we;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          rspBefore;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset_mem_addr", {2'b0, mem_addr}, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_mem_be", {28'b0, mem_be}, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, lat, rdata, err);
    checkOutput("lw0_rdata", rdata, 32'h44332211);
    checkOutput("lw0_latency", lat, 32'd2);
    checkOutput("lw0_err", {31'b0, err}, 32'd0);
    checkOutput("lw0_ntx", txLog.size(), 32'd1);
    if (txLog.size() >= 1) begin
      checkOutput("lw0_tx_addr", {2'b0, txLog[0].addr}, 32'd0);
      checkOutput("lw0_tx_be", {28'b0, txLog[0].be}, 32'hf);
      checkOutput("lw0_tx_we", {31'b0, txLog[0].we}, 32'd0);
    end

    applyStimulus(1'b0, 3'b000, 32'h3, 32'h0, lat, rdata, err);
    checkOutput("lw3_rdata", rdata, 32'h77665544);
    checkOutput("lw3_latency", lat, 32'd3);
    checkOutput("lw3_ntx", txLog.size(), 32'd2);
    if (txLog.size() >= 2) begin
      checkOutput("lw3_tx0_addr", {2'b0, txLog[0].addr}, 32'd0);
      checkOutput("lw3_tx1_addr", {2'b0, txLog[1].addr}, 32'd1);
    end

    applyStimulus(1'b0, 3'b011, 32'h7, 32'h0, lat, rdata, err);
    checkOutput("lb7_rdata", rdata, 32'hFFFFFF88);
    checkOutput("lb7_latency", lat, 32'd2);
    applyStimulus(1'b0, 3'b100, 32'h7, 32'h0, lat, rdata, err);
    checkOutput("lbu7_rdata", rdata, 32'h00000088);
    applyStimulus(1'b0, 3'b001, 32'h3, 32'h0, lat, rdata, err);
    checkOutput("lh3_rdata", rdata, 32'h00005544);
    checkOutput("lh3_latency", lat, 32'd3);
    applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, lat, rdata, err);
    checkOutput("lhu6_rdata", rdata, 32'h00008877);

    waitStates = 2;
    applyStimulus(1'b0, 3'b000, 32'h3, 32'h0, lat, rdata, err);
    checkOutput("lw3_wait2_rdata", rdata, 32'h77665544);
    checkOutput("lw3_wait2_latency", lat, 32'd7);
    applyStimulus(1'b0, 3'b001, 32'h1, 32'h0, lat, rdata, err);
    checkOutput("lh1_wait2_rdata", rdata, 32'h00003322);
    checkOutput("lh1_wait2_latency", lat, 32'd4);
    waitStates = 0;

    applyStimulus(1'b1, 3'b001, 32'h3, 32'h0000BEEF, lat, rdata, err);
    checkOutput("sh3_rdata", rdata, 32'h0);
    checkOutput("sh3_latency", lat, 32'd3);
    checkOutput("sh3_ntx", txLog.size(), 32'd2);
    if (txLog.size() >= 2) begin
      checkOutput("sh3_tx0_we", {31'b0, txLog[0].we}, 32'd1);
      checkOutput("sh3_tx0_addr", {2'b0, txLog[0].addr}, 32'd0);
      checkOutput("sh3_tx0_be", {28'b0, txLog[0].be}, 32'h8);
      checkOutput("sh3_tx0_wdata", txLog[0].wdata, 32'hEF000000);
      checkOutput("sh3_tx1_addr", {2'b0, txLog[1].addr}, 32'd1);
      checkOutput("sh3_tx1_be", {28'b0, txLog[1].be}, 32'h1);
      checkOutput("sh3_tx1_wdata", txLog[1].wdata, 32'h000000BE);
    end
    applyStimulus(1'b0, 3'b010, 32'h3, 32'h0, lat, rdata, err);
    checkOutput("lhu3_readback", rdata, 32'h0000BEEF);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, lat, rdata, err);
    checkOutput("lw0_after_store", rdata, 32'hEF332211);

    applyStimulus(1'b0, 3'b111, 32'h0, 32'h0, lat, rdata, err);
    checkOutput("bad_type_err", {31'b0, err}, 32'd1);
    checkOutput("bad_type_rdata", rdata, 32'h0);
    checkOutput("bad_type_latency", lat, 32'd1);
    checkOutput("bad_type_ntx", txLog.size(), 32'd0);

    // Abort a split load while the second word is pending.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_type  = 3'b000;
    req_addr  = 32'h2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    ackEn = 1'b0;
    checkOutput("abort_acc1_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("abort_acc1_mem_addr", {2'b0, mem_addr}, 32'd1);
    checkOutput("abort_acc1_stall", {31'b0, stall}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("abort_hold_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("abort_hold_mem_addr", {2'b0, mem_addr}, 32'd1);
    rspBefore = rspCount;
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("abort_mem_addr", {2'b0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ackEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_rsp", rspCount, rspBefore);
    forceAck = 1'b1;
    @(negedge clk);
    forceAck = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("late_ack_no_rsp", rspCount, rspBefore);

    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, lat, rdata, err);
    checkOutput("lw0_after_abort", rdata, 32'h44332211);
    checkOutput("lw0_after_abort_latency", lat, 32'd2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller on the CPU side of the data-memory interface. It sits between the MEM pipeline stage and a word-organised data memory. It accepts one byte, halfword or word request at a time and converts it into one or two word-wide memory transactions with byte enables. It assembles and sign- or zero-extends load data, and stalls the pipeline until the access completes.

## Interface
Parameters:
- `AW`, 32: byte-address width; the memory word address is `AW-2` bits.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; asynchronous, active-high.
- `req_valid` in 1: MEM stage presents a request.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_type` in 3: access type, using the shared `dm_*` codes.
- `req_addr` in AW: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: `req_type` code was invalid.
- `stall` out 1: high while a request is in flight (`!req_ready`).
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: transaction is a write.
- `mem_addr` out AW-2: word address.
- `mem_wdata` out 32: write word.
- `mem_be` out 4: byte enables; bit i covers bits 8i+7:8i.
- `mem_ack` in 1: transaction done this cycle; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
Access type codes and sizes:
- `dm_word`=000: 4 bytes.
- `dm_halfword`=001 and `dm_halfword_unsigned`=010: 2 bytes.
- `dm_byte`=011 and `dm_byte_unsigned`=100: 1 byte.
- 101–111 are invalid. Stores use the size only.

Addressing and data placement:
- Little-endian: access byte k lives at `req_addr+k`.
- `off = req_addr[1:0]`. `split = off + size > 4`.
- Word address `w = req_addr[AW-1:2]`. The second transaction goes to `w+1`, wrapping modulo 2^(AW-2).
- Store lanes: a 64-bit shifted data value is `{32'b0,wdata} << 8*off`. The 8-bit enable is `((1<<size)-1) << off`.
  - First transaction uses the low 32 bits and `be[3:0]`.
  - Second transaction uses the high 32 bits and `be[7:4]`.
  - Loads drive `mem_be` = 4'b1111 and `mem_wdata` = 0.
- Load assembly: `{hi,lo} >> 8*off`. `hi` is 0 when there is no split. The low `size` bytes are taken, then sign-extended for 001/011 and zero-extended for 010/100.

States:
- IDLE: `req_ready`=1. On `req_valid`, capture the request.
  - Valid type: go to ACC0.
  - Invalid type: go to RESP with err=1.
- ACC0: `mem_req`=1 with the first word.
  - On `mem_ack`, capture `lo`.
  - Go to ACC1 if split, else RESP.
- ACC1: `mem_req`=1 with word `w+1`. On `mem_ack`, capture `hi` and go to RESP.
- RESP: `rsp_valid`=1 for one cycle, then go to IDLE.

Other rules:
- All `mem_*` outputs and `rsp_*` outputs are registered or decoded from state. There are no combinational paths from `req_*` to `mem_*`.
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` stay stable until `mem_ack`.
- `mem_ack` is ignored outside ACC0 and ACC1.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready`=1, `stall`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- Latency, with acceptance at cycle T and zero-wait memory:
  - `mem_req` high at T+1.
  - Non-split access: `rsp_valid` at T+2.
  - Split access: second `mem_req` at T+2, `rsp_valid` at T+3.
  - Invalid type: `rsp_valid` at T+1.
  - Each memory wait cycle adds one cycle.
- The earliest next acceptance is the cycle after `rsp_valid`. `req_ready` is low in ACC0, ACC1 and RESP.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately, so `mem_req` drops without waiting for ack.
  - No `rsp_valid` is issued for the aborted request.
  - A later late `mem_ack` is ignored.
- Split store: the first word is written before the second. No rollback happens if the second transaction is reset away.

## Structure
- The `dm_*` codes, a `dm_size` function (type to 1/2/4) and the state encoding live in the shared `ctrl_encode_def` package/header.
- Sub-module `lsu_align`, purely combinational:
  - Inputs: off, type, wdata, lo, hi.
  - Outputs: shifted write words, the 8-bit byte-enable, and the extended load result.
- The FSM, capture registers and handshake logic live in `lsu_ctrl`.

## Test plan
Memory is preloaded with word0 = 0x44332211 and word1 = 0x88776655. The memory model acks with 0 and 2 wait states.
- lw at 0x0 → one read of word 0, `rsp_rdata`=0x44332211 at T+2 with zero wait states.
- lw at 0x3 → reads of word 0 then word 1, `rsp_rdata`=0x77665544 at T+3.
- lb at 0x7 → 0xFFFFFF88. lbu at 0x7 → 0x00000088. lh at 0x3 → 0x00005544. lhu at 0x6 → 0x00008877.
- sh at 0x3 with wdata 0x0000BEEF → two writes:
  - First: word 0, be=1000, wdata=0xEF000000.
  - Second: word 1, be=0001, wdata=0x000000BE.
  - Readback lhu at 0x3 → 0x0000BEEF.
- `req_type`=111 → no `mem_req`; `rsp_valid` and `rsp_err`=1 at T+1 with `rsp_rdata`=0.
- lw at 0x2 with `mem_ack` held low in ACC1, then `rst` pulsed → `mem_req`=0 in the same cycle, `req_ready`=1, no `rsp_valid`. A later ack has no effect.
